// File: rtl/pwmdac_pkg.sv
// Shared types and constants for the pwmdac_mc multi-channel PWM DAC.
// The LFSR helpers are only used when PWMDAC_DITHER_EN is defined.
package pwmdac_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int unsigned LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 expressed as a bit mask over [15:0]
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/pwmdac_chan.sv
// One PWM channel: pending/active sample buffers, duty selection and the output comparator.
// With PWMDAC_DITHER_EN the duty is active+dither (saturated), latched once per PWM period.
module pwmdac_chan
  import pwmdac_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_pend_i,
  input  logic             load_act_i,
`ifdef PWMDAC_DITHER_EN
  input  logic             latch_i,
  input  logic             dith_i,
`endif
  input  logic             run_i,
  input  logic [WIDTH-1:0] sample_i,
  input  logic [WIDTH-1:0] cnt_i,
  output logic             pwm_o
);

  logic [WIDTH-1:0] pend_q, pend_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic [WIDTH-1:0] duty_s;
  logic             pwm_q, pwm_d;

`ifdef PWMDAC_DITHER_EN
  logic [WIDTH-1:0] duty_q, duty_d;

  function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a, input logic b);
    logic [WIDTH:0] sum;
    sum = {1'b0, a} + {{WIDTH{1'b0}}, b};
    return sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
  endfunction
`endif

  // Buffer updates, duty selection and comparator
  always_comb begin
    pend_d   = load_pend_i ? sample_i : pend_q;
    active_d = load_act_i ? pend_q : active_q;
`ifdef PWMDAC_DITHER_EN
    // Latch from active_d so a frame loaded at the wrap is used in the period it starts
    duty_d   = latch_i ? sat_add(active_d, dith_i) : duty_q;
    duty_s   = duty_q;
`else
    duty_s   = active_q;
`endif
    pwm_d    = run_i && (duty_s > cnt_i);
  end

  // Channel state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q   <= {WIDTH{1'b0}};
      active_q <= {WIDTH{1'b0}};
      pwm_q    <= 1'b0;
`ifdef PWMDAC_DITHER_EN
      duty_q   <= {WIDTH{1'b0}};
`endif
    end else begin
      pend_q   <= pend_d;
      active_q <= active_d;
      pwm_q    <= pwm_d;
`ifdef PWMDAC_DITHER_EN
      duty_q   <= duty_d;
`endif
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/pwmdac_mc.sv
// Multi-channel PWM DAC: shared period/repeat counters, run FSM and frame handshake.
// Optional PWMDAC_DITHER_EN adds a 16-bit LFSR dither stepped once per PWM period.
module pwmdac_mc
  import pwmdac_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned REPEAT   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [CHANNELS*WIDTH-1:0]    sample_i,
  input  logic                         sample_valid,
  output logic                         sample_ready,
  output logic [CHANNELS-1:0]          pwm_o,
  output logic                         frame_o,
  output logic                         underrun_o
);

  localparam int unsigned REP_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT - 1);
  localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic             pend_full_q, pend_full_d;
  logic             frame_q, frame_d;
  logic             underrun_q, underrun_d;
  logic             run_s, wrap_s, bound_s, accept_s, load_act_s;

`ifdef PWMDAC_DITHER_EN
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
`endif

  // Next-state logic for FSM, counters, handshake and strobes
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = en ? ST_RUN : ST_IDLE;
      ST_RUN:  state_d = en ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // en gates the current cycle too, so dropping it blanks pwm_o on the very next edge
    run_s      = (state_q == ST_RUN) && en;
    wrap_s     = run_s && (cnt_q == CNT_MAX);
    bound_s    = wrap_s && (rep_q == REP_MAX);
    accept_s   = sample_valid && !pend_full_q;
    load_act_s = bound_s && pend_full_q;

    cnt_d = run_s ? (cnt_q + CNT_ONE) : {WIDTH{1'b0}};
    if (!run_s) begin
      rep_d = {REP_W{1'b0}};
    end else if (wrap_s) begin
      rep_d = (rep_q == REP_MAX) ? {REP_W{1'b0}} : (rep_q + REP_ONE);
    end else begin
      rep_d = rep_q;
    end

    if (accept_s) begin
      pend_full_d = 1'b1;
    end else if (load_act_s) begin
      pend_full_d = 1'b0;
    end else begin
      pend_full_d = pend_full_q;
    end

    frame_d    = load_act_s;
    underrun_d = bound_s && !pend_full_q;

`ifdef PWMDAC_DITHER_EN
    lfsr_d = wrap_s ? lfsr_next(lfsr_q) : lfsr_q;
`endif
  end

  // Shared control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {WIDTH{1'b0}};
      rep_q       <= {REP_W{1'b0}};
      pend_full_q <= 1'b0;
      frame_q     <= 1'b0;
      underrun_q  <= 1'b0;
`ifdef PWMDAC_DITHER_EN
      lfsr_q      <= LFSR_SEED;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rep_q       <= rep_d;
      pend_full_q <= pend_full_d;
      frame_q     <= frame_d;
      underrun_q  <= underrun_d;
`ifdef PWMDAC_DITHER_EN
      lfsr_q      <= lfsr_d;
`endif
    end
  end

  assign sample_ready = !pend_full_q;
  assign frame_o      = frame_q;
  assign underrun_o   = underrun_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    pwmdac_chan #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .load_pend_i(accept_s),
      .load_act_i (load_act_s),
`ifdef PWMDAC_DITHER_EN
      .latch_i    (wrap_s),
      .dith_i     (lfsr_q[c % LFSR_W]),
`endif
      .run_i      (run_s),
      .sample_i   (sample_i[c*WIDTH +: WIDTH]),
      .cnt_i      (cnt_q),
      .pwm_o      (pwm_o[c])
    );
  end

endmodule

// File: tb/tb_pwmdac_mc.sv
// Directed bench for pwmdac_mc (WIDTH=4, CHANNELS=2, REPEAT=2): duty table plus
// hand-written sequences for underrun, boundary-cycle offer, en drop and async reset.
module tb_pwmdac_mc;

  localparam int W  = 4;
  localparam int CH = 2;
  localparam int RP = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [CH*W-1:0] sample_i;
  logic            sample_valid;
  logic            sample_ready;
  logic [CH-1:0]   pwm_o;
  logic            frame_o;
  logic            underrun_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [3:0] ch0;
    logic [3:0] ch1;
    int         hi0;
    int         hi1;
  } vec_t;

  vec_t vecs[4];

  pwmdac_mc #(.WIDTH(W), .CHANNELS(CH), .REPEAT(RP)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .sample_i    (sample_i),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .pwm_o       (pwm_o),
    .frame_o     (frame_o),
    .underrun_o  (underrun_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Step until frame_o is seen (bounded); reports how often ready was high meanwhile
  task automatic wait_frame(output int rdy_hi);
    int waited;
    waited = 0;
    rdy_hi = 0;
    while (frame_o !== 1'b1 && waited < 40) begin
      step();
      waited++;
      if (frame_o !== 1'b1 && sample_ready === 1'b1) rdy_hi++;
    end
    check("frame_seen", {31'd0, frame_o}, 32'd1);
  endtask

  task automatic count_period(output int h0, output int h1);
    h0 = 0;
    h1 = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (pwm_o[0] === 1'b1) h0++;
      if (pwm_o[1] === 1'b1) h1++;
    end
  endtask

  initial begin
    int h0, h1, rdy_hi, base, last_f;

    vecs[0] = '{ch0: 4'h4, ch1: 4'hF, hi0: 4,  hi1: 15};
    vecs[1] = '{ch0: 4'h0, ch1: 4'h0, hi0: 0,  hi1: 0};
    vecs[2] = '{ch0: 4'hF, ch1: 4'h1, hi0: 15, hi1: 1};
    vecs[3] = '{ch0: 4'hC, ch1: 4'h8, hi0: 12, hi1: 8};

    // Reset with a frame offered: nothing may be accepted
    rst          = 1'b1;
    en           = 1'b0;
    sample_valid = 1'b1;
    sample_i     = 8'hFF;
    step();
    step();
    check("rst_pwm", {30'd0, pwm_o}, 32'd0);
    check("rst_strobes", {30'd0, frame_o, underrun_o}, 32'd0);
    rst          = 1'b0;
    sample_valid = 1'b0;
    check("rst_ready", {31'd0, sample_ready}, 32'd1);
    step();
    check("idle_pwm", {30'd0, pwm_o}, 32'd0);
    check("idle_ready", {31'd0, sample_ready}, 32'd1);

    // Duty table: one frame per boundary, 16-cycle high count per channel
    en     = 1'b1;
    base   = cyc;
    last_f = 0;
    for (int i = 0; i < 4; i++) begin
      sample_i     = {vecs[i].ch1, vecs[i].ch0};
      sample_valid = 1'b1;
      step();
      sample_valid = 1'b0;
      check("ready_after_accept", {31'd0, sample_ready}, 32'd0);
      wait_frame(rdy_hi);
      check("ready_held_low", rdy_hi, 32'd0);
      check("frame_no_underrun", {31'd0, underrun_o}, 32'd0);
      if (i == 0) check("first_frame_cycle", cyc - base, 32'd33);
      else        check("frame_period", cyc - last_f, 32'd32);
      last_f = cyc;
      count_period(h0, h1);
      check("duty_hi_ch0", h0, vecs[i].hi0);
      check("duty_hi_ch1", h1, vecs[i].hi1);
    end

    // No further frame: underrun at next boundary, last duty repeats
    check("ready_free", {31'd0, sample_ready}, 32'd1);
    repeat (15) step();
    check("underrun_not_early", {31'd0, underrun_o}, 32'd0);
    step();
    check("underrun_pulse", {31'd0, underrun_o}, 32'd1);
    check("underrun_no_frame", {31'd0, frame_o}, 32'd0);
    count_period(h0, h1);
    check("repeat_hi_ch0", h0, 32'd12);
    check("repeat_hi_ch1", h1, 32'd8);

    // Frame offered in the boundary cycle itself: underrun now, used 32 cycles later
    repeat (15) step();
    sample_i     = {4'h3, 4'hA};
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    check("bnd_offer_underrun", {31'd0, underrun_o}, 32'd1);
    check("bnd_offer_no_frame", {31'd0, frame_o}, 32'd0);
    check("bnd_offer_accepted", {31'd0, sample_ready}, 32'd0);
    repeat (31) step();
    check("bnd_frame_not_early", {31'd0, frame_o}, 32'd0);
    step();
    check("bnd_frame_late", {31'd0, frame_o}, 32'd1);
    count_period(h0, h1);
    check("bnd_hi_ch0", h0, 32'd10);
    check("bnd_hi_ch1", h1, 32'd3);

    // Drop en at cnt=7, then re-enable: period restarts at cnt=0, rep=0
    repeat (7) step();
    check("pwm_before_drop", {31'd0, pwm_o[0]}, 32'd1);
    en = 1'b0;
    step();
    check("pwm_after_drop", {30'd0, pwm_o}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("idle_quiet", {29'd0, pwm_o, frame_o, underrun_o}, 32'd0);
    end
    en = 1'b1;
    step();
    check("reen_first", {30'd0, pwm_o}, 32'd0);
    for (int k = 0; k < 16; k++) begin
      step();
      check("reen_ch0", {31'd0, pwm_o[0]}, (k < 10) ? 32'd1 : 32'd0);
      check("reen_ch1", {31'd0, pwm_o[1]}, (k < 3) ? 32'd1 : 32'd0);
    end
    repeat (15) step();
    check("reen_underrun_not_early", {31'd0, underrun_o}, 32'd0);
    step();
    check("reen_underrun", {31'd0, underrun_o}, 32'd1);

    // Asynchronous reset mid-period with a pending frame
    sample_i     = {4'h1, 4'h5};
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    check("pre_rst_pend", {31'd0, sample_ready}, 32'd0);
    repeat (3) step();
    check("pwm_before_rst", {30'd0, pwm_o}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("pwm_async_rst", {30'd0, pwm_o}, 32'd0);
    check("ready_async_rst", {31'd0, sample_ready}, 32'd1);
    step();
    step();
    rst = 1'b0;
    check("ready_after_rst", {31'd0, sample_ready}, 32'd1);
    for (int k = 0; k < 20; k++) begin
      step();
      check("post_rst_quiet", {29'd0, pwm_o, frame_o, underrun_o}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
